// File: rtl/rs255_247_syndrome.sv
// rs255_247_syndrome: streaming syndrome calculator for RS(255,247) over GF(2^8), p(x)=0x11D, alpha=0x02
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     input symbol valid
//   in_ready     block can accept a symbol
//   in_data      received symbol, highest degree first
//   in_first     first symbol of a codeword (restarts accumulation)
//   in_last      last symbol of a codeword (r_0)
//   out_valid    syndrome result valid (1-deep holding register)
//   out_ready    downstream accepts the result
//   out_syn      S_j = r(alpha^(FCR+j)) in bits [8j+7:8j]
//   out_err      any syndrome nonzero
//   out_len_err  codeword length was not N symbols
module rs255_247_syndrome #(
    parameter int N    = 255,
    parameter int NSYM = 8,
    parameter int FCR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8*NSYM-1:0] out_syn,
    output logic              out_err,
    output logic              out_len_err
);
    localparam int CW = $clog2(N + 2);

    typedef enum logic {IDLE, ACC} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e % 255; i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    state_t            r_state, w_state_nxt;
    logic [8*NSYM-1:0] r_acc, w_syn, r_syn;
    logic [CW-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic              r_valid, r_err, r_len_err;
    logic              w_accept, w_load, w_step, w_done;

    // Multiplier operands are elaboration constants, so each lane reduces to an XOR network.
    for (genvar j = 0; j < NSYM; j++) begin : g_lane
        localparam logic [7:0] ROOT = gf_pow(FCR + j);
        assign w_syn[8*j +: 8] = w_load ? in_data : gf_mul(r_acc[8*j +: 8], ROOT) ^ in_data;
    end

    // The accumulators are independent of the holding register, so only a symbol that
    // would overwrite a pending, undelivered result has to wait.
    assign in_ready  = !(r_valid && !out_ready && in_last);
    assign w_accept  = in_valid && in_ready;
    assign w_load    = w_accept && in_first;
    assign w_step    = w_accept && !in_first && r_state == ACC;
    assign w_done    = (w_load || w_step) && in_last;
    assign w_cnt_inc = (r_cnt == CW'(N + 1)) ? r_cnt : r_cnt + CW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_load) w_cnt_nxt = CW'(1);
        else if (w_step) w_cnt_nxt = w_cnt_inc;
        if (w_done) w_state_nxt = IDLE;
        else if (w_load) w_state_nxt = ACC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_syn     <= '0;
            r_err     <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load || w_step) r_acc <= w_syn;
            // A new result on the same edge as a handshake keeps out_valid high (no bubble).
            if (w_done) begin
                r_valid   <= 1'b1;
                r_syn     <= w_syn;
                r_err     <= |w_syn;
                r_len_err <= w_cnt_nxt != CW'(N);
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_syn     = r_syn;
    assign out_err     = r_err;
    assign out_len_err = r_len_err;
endmodule

// File: tb/tb_rs255_247_syndrome.sv
// tb_rs255_247_syndrome: directed self-checking bench for rs255_247_syndrome
module tb_rs255_247_syndrome;
    localparam int LIM = 1000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, out_valid, out_err, out_len_err;
    logic [63:0] out_syn;

    int n_cmp = 0, n_bad = 0, cyc = 0, stalls = 0, n_res = 0, rd = 0, s0 = 0;
    logic [63:0] m_syn [0:63];
    logic        m_err [0:63];
    logic        m_len [0:63];
    int          m_cyc [0:63];

    logic [7:0] gexp [0:254];
    int         glog [0:255];
    logic [7:0] g  [0:8];
    logic [7:0] cw [0:254];
    logic [7:0] st [0:299];
    logic [63:0] e_syn;

    rs255_247_syndrome dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_syn(out_syn), .out_err(out_err), .out_len_err(out_len_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (in_valid && !in_ready) stalls <= stalls + 1;
        if (rst_n && out_valid && out_ready) begin
            m_syn[n_res % 64] <= out_syn;
            m_err[n_res % 64] <= out_err;
            m_len[n_res % 64] <= out_len_err;
            m_cyc[n_res % 64] <= cyc;
            n_res <= n_res + 1;
        end
    end

    initial begin
        #5_000_000;
        $error("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        return (a == 8'h00 || b == 8'h00) ? 8'h00 : gexp[(glog[a] + glog[b]) % 255];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic f, input logic l);
        int w;
        w = 0;
        in_valid = 1'b1; in_data = d; in_first = f; in_last = l;
        @(negedge clk);
        while (!in_ready && w < LIM) begin
            w++;
            @(negedge clk);
        end
        if (w >= LIM) begin
            n_cmp++;
            n_bad++;
            $error("FAIL send_timeout: observed stalled %0d cycles expected accept", w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_stream(input int n, input logic f, input logic l);
        for (int i = 0; i < n; i++) send(st[i], f && i == 0, l && i == n - 1);
    endtask

    task automatic fill_st(input logic [7:0] v);
        for (int i = 0; i < 300; i++) st[i] = v;
    endtask

    task automatic load_st();
        for (int i = 0; i < 255; i++) st[i] = cw[254 - i];
    endtask

    task automatic gen_cw();
        logic [7:0] m [0:246];
        for (int k = 0; k < 247; k++) m[k] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 255; i++) cw[i] = 8'h00;
        for (int k = 0; k < 247; k++)
            for (int t = 0; t < 9; t++) cw[k + t] = cw[k + t] ^ mul(m[k], g[t]);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string tag, input logic [63:0] syn, input logic err, input logic len);
        chk({tag, "_avail"}, 64'(n_res > rd), 64'd1);
        if (n_res > rd) begin
            chk({tag, "_syn"}, m_syn[rd % 64], syn);
            chk({tag, "_err"}, 64'(m_err[rd % 64]), 64'(err));
            chk({tag, "_len"}, 64'(m_len[rd % 64]), 64'(len));
            rd++;
        end
    endtask

    initial begin
        logic [7:0] x;
        int ca;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        glog[0] = 0;
        g[0] = 8'h01;
        for (int i = 1; i < 9; i++) g[i] = 8'h00;
        for (int j = 0; j < 8; j++)
            for (int i = 8; i >= 0; i--) g[i] = (i > 0 ? g[i - 1] : 8'h00) ^ mul(g[i], gexp[j]);

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_syn", out_syn, 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_out_len_err", 64'(out_len_err), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        fill_st(8'h00);
        send_stream(255, 1'b1, 1'b1);
        chk("t1_latency", 64'(out_valid), 64'd1);
        settle();
        expect_res("t1", 64'h0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("t1_single_pulse", 64'(n_res - rd), 64'd0);
        chk("t1_valid_drop", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        send(8'hAA, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b1);
        fill_st(8'h00);
        st[254] = 8'h01;
        send_stream(255, 1'b1, 1'b1);
        settle();
        chk("t2_count", 64'(n_res - rd), 64'd1);
        expect_res("t2", 64'h0101010101010101, 1'b1, 1'b0);
        chk("t2_hold_syn", out_syn, 64'h0101010101010101);

        fill_st(8'h00);
        st[253] = 8'h01;
        send_stream(255, 1'b1, 1'b1);
        settle();
        expect_res("t3", 64'h8040201008040201, 1'b1, 1'b0);

        s0 = stalls;
        gen_cw();
        load_st();
        send_stream(255, 1'b1, 1'b1);
        gen_cw();
        load_st();
        send_stream(255, 1'b1, 1'b1);
        settle();
        chk("t4_no_stall", 64'(stalls - s0), 64'd0);
        ca = m_cyc[rd % 64];
        expect_res("t4a", 64'h0, 1'b0, 1'b0);
        chk("t4_period", 64'(m_cyc[rd % 64] - ca), 64'd255);
        expect_res("t4b", 64'h0, 1'b0, 1'b0);
        cw[100] = cw[100] ^ 8'h5A;
        load_st();
        for (int j = 0; j < 8; j++) e_syn[8*j +: 8] = mul(8'h5A, gexp[(j * 100) % 255]);
        send_stream(255, 1'b1, 1'b1);
        settle();
        expect_res("t4_inject", e_syn, 1'b1, 1'b0);

        out_ready = 1'b0;
        fill_st(8'h00);
        st[254] = 8'h01;
        send_stream(255, 1'b1, 1'b1);
        fill_st(8'h00);
        st[253] = 8'h01;
        s0 = stalls;
        for (int i = 0; i < 254; i++) send(st[i], i == 0, 1'b0);
        chk("t5_accum_no_stall", 64'(stalls - s0), 64'd0);
        fork
            send(st[254], 1'b0, 1'b1);
            begin
                repeat (4) @(negedge clk);
                chk("t5_in_ready_low", 64'(in_ready), 64'd0);
                chk("t5_pending_valid", 64'(out_valid), 64'd1);
                chk("t5_pending_syn", out_syn, 64'h0101010101010101);
                chk("t5_pending_err", 64'(out_err), 64'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        settle();
        chk("t5_stall_seen", 64'(stalls - s0 >= 3), 64'd1);
        ca = m_cyc[rd % 64];
        expect_res("t5a", 64'h0101010101010101, 1'b1, 1'b0);
        chk("t5_no_bubble", 64'(m_cyc[rd % 64] - ca), 64'd1);
        expect_res("t5b", 64'h8040201008040201, 1'b1, 1'b0);

        fill_st(8'h00);
        send_stream(10, 1'b1, 1'b1);
        settle();
        expect_res("t6_short", 64'h0, 1'b0, 1'b1);
        send(8'h3C, 1'b1, 1'b1);
        settle();
        expect_res("t6_single", 64'h3C3C3C3C3C3C3C3C, 1'b1, 1'b1);
        fill_st(8'h00);
        st[299] = 8'h01;
        send_stream(300, 1'b1, 1'b1);
        settle();
        expect_res("t6_long", 64'h0101010101010101, 1'b1, 1'b1);
        fill_st(8'hFF);
        send_stream(100, 1'b1, 1'b0);
        fill_st(8'h00);
        st[254] = 8'h01;
        send_stream(255, 1'b1, 1'b1);
        settle();
        chk("t6_abort_count", 64'(n_res - rd), 64'd1);
        expect_res("t6_restart", 64'h0101010101010101, 1'b1, 1'b0);

        out_ready = 1'b0;
        fill_st(8'h11);
        send_stream(10, 1'b1, 1'b1);
        chk("t6_pre_rst_valid", 64'(out_valid), 64'd1);
        chk("t6_pre_rst_len", 64'(out_len_err), 64'd1);
        fill_st(8'h22);
        send_stream(50, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_syn", out_syn, 64'd0);
        chk("t6_rst_err", 64'(out_err), 64'd0);
        chk("t6_rst_len", 64'(out_len_err), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        fill_st(8'h00);
        st[253] = 8'h01;
        send_stream(255, 1'b1, 1'b1);
        settle();
        chk("t6_post_rst_count", 64'(n_res - rd), 64'd1);
        expect_res("t6_post_rst", 64'h8040201008040201, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
